load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Multicycle load/store sequencer between the CPU datapath and the memory interface bus.
//  Turns one RV32I load/store request (funct3, byte address) into bus transactions:
//  byte enables, lane-shifted write data, aligned word addresses.
//  Realigns and sign/zero-extends read data; answers with a one-cycle done pulse.
// PARAMETERS
//  RD_LATENCY  1  cycles from bus address/enable valid to iReadData valid (legal 1..3)
//  CNT_W       2  width of phase cycle counter; must hold RD_LATENCY
// PORTS
//  iCLK          in   1   sole clock; all state updates on rising edge
//  iRST_n        in   1   synchronous reset, active-low
//  iReq          in   1   request strobe; accepted only while oReady=1
//  iWrite        in   1   1=store, 0=load
//  iFunct3       in   3   RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
//  iAddr         in   32  byte address
//  iWData        in   32  store data, right-aligned
//  oReady        out  1   idle, can accept a request
//  oDone         out  1   one-cycle pulse: access finished (or faulted)
//  oRData        out  32  extended load result; valid with oDone, held until next oDone
//  oMisaligned   out  1   valid with oDone: access crossed word and was not performed
//  oIllegal      out  1   valid with oDone: unsupported funct3, no bus activity
//  oReadEnable   out  1   to memory bus
//  oWriteEnable  out  1   to memory bus
//  oByteEnable   out  4   to memory bus
//  oAddress      out  32  to memory bus, always word-aligned ([1:0]=0)
//  oWriteData    out  32  to memory bus, lane-shifted
//  iReadData     in   32  from memory bus
// BEHAVIOUR
//  Reset (iRST_n=0 at edge) values:
//   state=IDLE; oReady=1; oDone/oMisaligned/oIllegal=0; oRData=0.
//   Bus outputs: enables=0, oByteEnable=0, oAddress=0, oWriteData=0.
//  Reset mid-access: abort at that edge; store phase already issued stays written.
//  Acceptance and latching:
//   iReq && oReady at edge latches iWrite/iFunct3/iAddr/iWData; later input changes ignored.
//   iReq while busy is dropped (no queueing).
//  Masks: o=addr[1:0]; n=1/2/4 bytes by funct3[1:0].
//   m8 = ((1<<n)-1)<<o (8 bits); w64 = {32'b0,iWData}<<(8*o).
//   Access is split iff m8[7:4]!=0.
//  FSM: IDLE -> PH1 -> [PH2] -> RESP -> IDLE.
//   Illegal funct3 or misaligned (no split): IDLE -> RESP, flag set.
//   PH1: oAddress=addr&~3; oByteEnable=m8[3:0]; oWriteData=w64[31:0].
//   PH2: oAddress=(addr&~3)+4, wraps mod 2^32; oByteEnable=m8[7:4]; oWriteData=w64[63:32].
//   Each phase lasts RD_LATENCY+1 cycles; address/enables stable throughout.
//   oReadEnable=1 for every cycle of a load phase.
//   oWriteEnable=1 only in the first cycle of a store phase (one write per phase).
//   Loads capture iReadData in the last cycle of each phase into lo/hi word regs.
//   RESP: oDone=1 one cycle; oReady=0 in PH1/PH2/RESP.
//   Load result: oRData = ({hi,lo}>>(8*o)), sign-extended (LB/LH) or zero-extended (LBU/LHU).
//  Latency (L=RD_LATENCY): accept at edge 0; oDone high in cycle L+2 (aligned), 2L+3 (split).
//   Back-to-back request accepted in the cycle after RESP.
//  Illegal funct3: loads 011/110/111; stores 011..111.
//   Misaligned flag not raised when illegal.
//   On any fault oRData keeps its previous value.
// CONFIGURATION
//  MISALIGN_SPLIT_EN defined:
//   word-crossing accesses run PH1+PH2; oMisaligned never asserted.
//  MISALIGN_SPLIT_EN undefined:
//   PH2 and hi register not built; word-crossing access goes IDLE->RESP.
//   oDone=1 with oMisaligned=1, no bus enables asserted.
// TESTING
//  1 LW 0x10010004, mem=0xDEADBEEF, L=1 -> BE=1111, RE 2 cyc, oDone at cycle 3, oRData=0xDEADBEEF
//  2 SB 0x10010003, iWData=0x000000A5 -> one WE pulse, BE=1000, oWriteData=0xA5000000
//  3 LB 0x10010002 (byte 0x80) -> 0xFFFFFF80; LBU same address -> 0x00000080
//  4 LW 0x10010006, words 0x44332211|0x88776655, split EN -> BE 1100 then 0011,
//    addr +4, oRData=0x66554433, oDone at cycle 5; split off -> oMisaligned=1 cycle 1, no RE/WE
//  5 iFunct3=011 load -> oIllegal=1 at cycle 1, no bus activity, oRData unchanged
//  6 iRST_n=0 during PH1 of store -> all bus outputs 0 and oReady=1 after that edge;
//    iReq while busy ignored

Source files
------------

// File: rtl/load_store_unit.sv
// RV32I load/store sequencer: turns one request into 1-2 word-aligned bus phases and realigns load data.
// Build option MISALIGN_SPLIT_EN: word-crossing accesses run as two phases instead of faulting.
module load_store_unit #(
    parameter int RD_LATENCY = 1,
    parameter int CNT_W      = 2
) (
    input  logic        iCLK,
    input  logic        iRST_n,
    input  logic        iReq,
    input  logic        iWrite,
    input  logic [2:0]  iFunct3,
    input  logic [31:0] iAddr,
    input  logic [31:0] iWData,
    output logic        oReady,
    output logic        oDone,
    output logic [31:0] oRData,
    output logic        oMisaligned,
    output logic        oIllegal,
    output logic        oReadEnable,
    output logic        oWriteEnable,
    output logic [3:0]  oByteEnable,
    output logic [31:0] oAddress,
    output logic [31:0] oWriteData,
    input  logic [31:0] iReadData
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PH1  = 2'd1,
        ST_RESP = 2'd2
`ifdef MISALIGN_SPLIT_EN
        , ST_PH2 = 2'd3
`endif
    } state_e;

    function automatic logic [7:0] byte_mask(input logic [1:0] size, input logic [1:0] off);
        logic [7:0] base;
        case (size)
            2'b00:   base = 8'h01;
            2'b01:   base = 8'h03;
            default: base = 8'h0F;
        endcase
        return base << off;
    endfunction

    function automatic logic [31:0] lane_data(input logic [31:0] d, input logic [1:0] off,
                                              input logic hi);
        logic [63:0] w;
        w = {32'b0, d} << {off, 3'b000};
        return hi ? w[63:32] : w[31:0];
    endfunction

    function automatic logic is_illegal(input logic wr, input logic [2:0] f3);
        if (wr) return f3[2] || (f3[1:0] == 2'b11);
        return (f3[1:0] == 2'b11) || (f3 == 3'b110);
    endfunction

    function automatic logic [31:0] load_result(input logic [31:0] lo, input logic [31:0] hi,
                                                input logic [1:0] off, input logic [2:0] f3);
        logic [31:0] r;
        r = 32'({hi, lo} >> {off, 3'b000});
        case (f3)
            3'b000:  return {{24{r[7]}}, r[7:0]};
            3'b001:  return {{16{r[15]}}, r[15:0]};
            3'b100:  return {24'b0, r[7:0]};
            3'b101:  return {16'b0, r[15:0]};
            default: return r;
        endcase
    endfunction

    state_e           state_q, state_d;
    logic             ready_q, ready_d, done_q, done_d, mis_q, mis_d, ill_q, ill_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             re_q, re_d, we_q, we_d;
    logic [3:0]       be_q, be_d;
    logic [31:0]      baddr_q, baddr_d, bwd_q, bwd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             write_q, write_d;
    logic [2:0]       f3_q, f3_d;
    logic [1:0]       off_q, off_d;
    logic [31:0]      lo_q, lo_d, lo_n, hi_n;
    logic [7:0]       m8_in;
    logic             phase_last, finish;
`ifdef MISALIGN_SPLIT_EN
    logic [29:0]      wa_q, wa_d;
    logic [31:0]      wdata_q, wdata_d, hi_q, hi_d;
    logic [7:0]       m8_lat;

    assign m8_lat = byte_mask(f3_q[1:0], off_q);
    assign hi_n   = (state_q == ST_PH2 && phase_last) ? iReadData : hi_q;
`else
    assign hi_n   = '0;
`endif

    assign m8_in      = byte_mask(iFunct3[1:0], iAddr[1:0]);
    assign phase_last = (cnt_q == CNT_W'(RD_LATENCY));
    // Read data is valid in the last cycle of a phase; use it directly so oRData lands with oDone.
    assign lo_n       = (state_q == ST_PH1 && phase_last) ? iReadData : lo_q;

    always_comb begin
        state_d = state_q;
        ready_d = ready_q;
        done_d  = 1'b0;
        mis_d   = mis_q;
        ill_d   = ill_q;
        rdata_d = rdata_q;
        re_d    = re_q;
        we_d    = 1'b0;
        be_d    = be_q;
        baddr_d = baddr_q;
        bwd_d   = bwd_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        f3_d    = f3_q;
        off_d   = off_q;
        lo_d    = lo_n;
        finish  = 1'b0;
`ifdef MISALIGN_SPLIT_EN
        wa_d    = wa_q;
        wdata_d = wdata_q;
        hi_d    = hi_n;
`endif
        case (state_q)
            ST_IDLE: begin
                if (iReq) begin
                    write_d = iWrite;
                    f3_d    = iFunct3;
                    off_d   = iAddr[1:0];
`ifdef MISALIGN_SPLIT_EN
                    wa_d    = iAddr[31:2];
                    wdata_d = iWData;
`endif
                    ready_d = 1'b0;
                    ill_d   = 1'b0;
                    mis_d   = 1'b0;
                    if (is_illegal(iWrite, iFunct3)) begin
                        state_d = ST_RESP;
                        done_d  = 1'b1;
                        ill_d   = 1'b1;
                    end
`ifndef MISALIGN_SPLIT_EN
                    else if (|m8_in[7:4]) begin
                        state_d = ST_RESP;
                        done_d  = 1'b1;
                        mis_d   = 1'b1;
                    end
`endif
                    else begin
                        state_d = ST_PH1;
                        cnt_d   = '0;
                        baddr_d = {iAddr[31:2], 2'b00};
                        be_d    = m8_in[3:0];
                        bwd_d   = lane_data(iWData, iAddr[1:0], 1'b0);
                        re_d    = ~iWrite;
                        we_d    = iWrite;
                    end
                end
            end
            ST_PH1: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (phase_last) begin
`ifdef MISALIGN_SPLIT_EN
                    if (|m8_lat[7:4]) begin
                        state_d = ST_PH2;
                        cnt_d   = '0;
                        baddr_d = {wa_q + 30'd1, 2'b00};
                        be_d    = m8_lat[7:4];
                        bwd_d   = lane_data(wdata_q, off_q, 1'b1);
                        we_d    = write_q;
                    end else begin
                        finish = 1'b1;
                    end
`else
                    finish = 1'b1;
`endif
                end
            end
`ifdef MISALIGN_SPLIT_EN
            ST_PH2: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (phase_last) finish = 1'b1;
            end
`endif
            ST_RESP: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        if (finish) begin
            state_d = ST_RESP;
            done_d  = 1'b1;
            re_d    = 1'b0;
            be_d    = '0;
            baddr_d = '0;
            bwd_d   = '0;
            if (!write_q) rdata_d = load_result(lo_n, hi_n, off_q, f3_q);
        end
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_n) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            mis_q   <= 1'b0;
            ill_q   <= 1'b0;
            rdata_q <= '0;
            re_q    <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= '0;
            baddr_q <= '0;
            bwd_q   <= '0;
            cnt_q   <= '0;
            write_q <= 1'b0;
            f3_q    <= '0;
            off_q   <= '0;
            lo_q    <= '0;
`ifdef MISALIGN_SPLIT_EN
            wa_q    <= '0;
            wdata_q <= '0;
            hi_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            mis_q   <= mis_d;
            ill_q   <= ill_d;
            rdata_q <= rdata_d;
            re_q    <= re_d;
            we_q    <= we_d;
            be_q    <= be_d;
            baddr_q <= baddr_d;
            bwd_q   <= bwd_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            lo_q    <= lo_d;
`ifdef MISALIGN_SPLIT_EN
            wa_q    <= wa_d;
            wdata_q <= wdata_d;
            hi_q    <= hi_d;
`endif
        end
    end

    assign oReady       = ready_q;
    assign oDone        = done_q;
    assign oRData       = rdata_q;
    assign oMisaligned  = mis_q;
    assign oIllegal     = ill_q;
    assign oReadEnable  = re_q;
    assign oWriteEnable = we_q;
    assign oByteEnable  = be_q;
    assign oAddress     = baddr_q;
    assign oWriteData   = bwd_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit (RD_LATENCY=1): vector table plus reset/busy sequences.
module tb_load_store_unit;

    logic        iCLK = 1'b0;
    logic        iRST_n, iReq, iWrite;
    logic [2:0]  iFunct3;
    logic [31:0] iAddr, iWData, iReadData;
    logic        oReady, oDone, oMisaligned, oIllegal, oReadEnable, oWriteEnable;
    logic [31:0] oRData, oAddress, oWriteData;
    logic [3:0]  oByteEnable;

    load_store_unit #(.RD_LATENCY(1), .CNT_W(2)) dut (
        .iCLK(iCLK), .iRST_n(iRST_n), .iReq(iReq), .iWrite(iWrite), .iFunct3(iFunct3),
        .iAddr(iAddr), .iWData(iWData), .oReady(oReady), .oDone(oDone), .oRData(oRData),
        .oMisaligned(oMisaligned), .oIllegal(oIllegal), .oReadEnable(oReadEnable),
        .oWriteEnable(oWriteEnable), .oByteEnable(oByteEnable), .oAddress(oAddress),
        .oWriteData(oWriteData), .iReadData(iReadData)
    );

    always #5 iCLK = ~iCLK;

    // One-cycle read latency memory: 16 words indexed by address bits [5:2].
    logic [31:0] mem [16];
    always @(posedge iCLK) iReadData <= mem[oAddress[5:2]];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr, wdata, mem0, mem1;
        int          done_cyc;
        logic [31:0] rdata;
        logic [3:0]  be;
        logic [31:0] baddr, wd;
        int          re_n, we_n;
        logic        mis, ill;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic wr, logic [2:0] f3, logic [31:0] addr, logic [31:0] wdata,
                                logic [31:0] mem0, logic [31:0] mem1, int done_cyc,
                                logic [31:0] rdata, logic [3:0] be, logic [31:0] baddr,
                                logic [31:0] wd, int re_n, int we_n, logic mis, logic ill);
        vec_t v;
        v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.mem0 = mem0; v.mem1 = mem1;
        v.done_cyc = done_cyc; v.rdata = rdata; v.be = be; v.baddr = baddr; v.wd = wd;
        v.re_n = re_n; v.we_n = we_n; v.mis = mis; v.ill = ill;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge iCLK);
        #1;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int          cyc, re_n, we_n, done_cyc, wait_n;
        logic [3:0]  be1;
        logic [31:0] a1, wd1;
        logic        rdy1, fault;
        logic [3:0]  mi;
        string       tag;
        tag   = $sformatf("v%0d", idx);
        fault = v.mis | v.ill;
        mi    = v.addr[5:2];
        mem[mi]        = v.mem0;
        mem[mi + 4'd1] = v.mem1;
        wait_n = 0;
        while (!oReady && wait_n < 20) begin
            tick();
            wait_n++;
        end
        iReq = 1'b1; iWrite = v.wr; iFunct3 = v.f3; iAddr = v.addr; iWData = v.wdata;
        tick();
        // Scramble inputs after acceptance; the unit must use its latched copy.
        iReq = 1'b0; iWrite = ~v.wr; iFunct3 = 3'b010; iAddr = ~v.addr; iWData = ~v.wdata;
        cyc = 1; re_n = 0; we_n = 0; done_cyc = 0;
        be1 = '0; a1 = '0; wd1 = '0; rdy1 = 1'b1;
        while (cyc <= 20) begin
            if (cyc == 1) begin
                be1 = oByteEnable; a1 = oAddress; wd1 = oWriteData; rdy1 = oReady;
            end
            re_n += int'(oReadEnable);
            we_n += int'(oWriteEnable);
            if (oDone) begin
                done_cyc = cyc;
                break;
            end
            tick();
            cyc++;
        end
        chk({tag, " done_cycle"}, 32'(done_cyc), 32'(v.done_cyc));
        chk({tag, " rdata"}, oRData, v.rdata);
        chk({tag, " misaligned"}, 32'(oMisaligned), 32'(v.mis));
        chk({tag, " illegal"}, 32'(oIllegal), 32'(v.ill));
        chk({tag, " byte_enable"}, 32'(be1), 32'(v.be));
        chk({tag, " re_cycles"}, 32'(re_n), 32'(v.re_n));
        chk({tag, " we_pulses"}, 32'(we_n), 32'(v.we_n));
        chk({tag, " ready_busy"}, 32'(rdy1), 32'h0);
        if (!fault) chk({tag, " bus_addr"}, a1, v.baddr);
        if (v.wr && !fault) chk({tag, " write_data"}, wd1, v.wd);
        tick();
        chk({tag, " ready_after"}, 32'(oReady), 32'h1);
    endtask

    initial begin
        int we_seen, wait_n;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        iRST_n = 1'b0; iReq = 1'b0; iWrite = 1'b0; iFunct3 = '0; iAddr = '0; iWData = '0;
        tick();
        tick();
        chk("rst ready", 32'(oReady), 32'h1);
        chk("rst done", 32'(oDone), 32'h0);
        chk("rst flags", {30'b0, oMisaligned, oIllegal}, 32'h0);
        chk("rst rdata", oRData, 32'h0);
        chk("rst enables", {29'b0, oReadEnable, oWriteEnable, 1'b0}, 32'h0);
        chk("rst be", 32'(oByteEnable), 32'h0);
        chk("rst addr", oAddress, 32'h0);
        chk("rst wdata", oWriteData, 32'h0);
        iRST_n = 1'b1;
        tick();

        //           wr  f3      addr          wdata         mem0          mem1          dc rdata         be     baddr         wd            re we mis ill
        vecs.push_back(mk(0, 3'b010, 32'h10010004, 32'h0,        32'hDEADBEEF, 32'h0,        3, 32'hDEADBEEF, 4'hF, 32'h10010004, 32'h0,        2, 0, 0, 0));
        vecs.push_back(mk(1, 3'b000, 32'h10010003, 32'h000000A5, 32'h0,        32'h0,        3, 32'hDEADBEEF, 4'h8, 32'h10010000, 32'hA5000000, 0, 1, 0, 0));
        vecs.push_back(mk(0, 3'b000, 32'h10010002, 32'h0,        32'h92803456, 32'h0,        3, 32'hFFFFFF80, 4'h4, 32'h10010000, 32'h0,        2, 0, 0, 0));
        vecs.push_back(mk(0, 3'b100, 32'h10010002, 32'h0,        32'h92803456, 32'h0,        3, 32'h00000080, 4'h4, 32'h10010000, 32'h0,        2, 0, 0, 0));
        vecs.push_back(mk(0, 3'b001, 32'h10010002, 32'h0,        32'h92803456, 32'h0,        3, 32'hFFFF9280, 4'hC, 32'h10010000, 32'h0,        2, 0, 0, 0));
        vecs.push_back(mk(0, 3'b101, 32'h10010002, 32'h0,        32'h92803456, 32'h0,        3, 32'h00009280, 4'hC, 32'h10010000, 32'h0,        2, 0, 0, 0));
        vecs.push_back(mk(1, 3'b001, 32'h10010002, 32'h1234BEEF, 32'h0,        32'h0,        3, 32'h00009280, 4'hC, 32'h10010000, 32'hBEEF0000, 0, 1, 0, 0));
        vecs.push_back(mk(1, 3'b010, 32'h10010008, 32'hCAFEF00D, 32'h0,        32'h0,        3, 32'h00009280, 4'hF, 32'h10010008, 32'hCAFEF00D, 0, 1, 0, 0));
        vecs.push_back(mk(0, 3'b011, 32'h10010004, 32'h0,        32'h0,        32'h0,        1, 32'h00009280, 4'h0, 32'h0,        32'h0,        0, 0, 0, 1));
        vecs.push_back(mk(1, 3'b100, 32'h10010004, 32'h0,        32'h0,        32'h0,        1, 32'h00009280, 4'h0, 32'h0,        32'h0,        0, 0, 0, 1));
        vecs.push_back(mk(0, 3'b111, 32'h10010006, 32'h0,        32'h0,        32'h0,        1, 32'h00009280, 4'h0, 32'h0,        32'h0,        0, 0, 0, 1));
`ifdef MISALIGN_SPLIT_EN
        vecs.push_back(mk(0, 3'b010, 32'h10010006, 32'h0,        32'h44332211, 32'h88776655, 5, 32'h66554433, 4'hC, 32'h10010004, 32'h0,        4, 0, 0, 0));
        vecs.push_back(mk(1, 3'b001, 32'h10010003, 32'h0000ABCD, 32'h0,        32'h0,        5, 32'h66554433, 4'h8, 32'h10010000, 32'hCD000000, 0, 2, 0, 0));
`else
        vecs.push_back(mk(0, 3'b010, 32'h10010006, 32'h0,        32'h44332211, 32'h88776655, 1, 32'h00009280, 4'h0, 32'h0,        32'h0,        0, 0, 1, 0));
        vecs.push_back(mk(1, 3'b001, 32'h10010003, 32'h0000ABCD, 32'h0,        32'h0,        1, 32'h00009280, 4'h0, 32'h0,        32'h0,        0, 0, 1, 0));
`endif
        vecs.push_back(mk(0, 3'b000, 32'h10010007, 32'h0,        32'h44332211, 32'h0,        3, 32'h00000044, 4'h8, 32'h10010004, 32'h0,        2, 0, 0, 0));
        vecs.push_back(mk(0, 3'b010, 32'hFFFFFFFC, 32'h0,        32'h0BADF00D, 32'h0,        3, 32'h0BADF00D, 4'hF, 32'hFFFFFFFC, 32'h0,        2, 0, 0, 0));

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // A request raised while busy must be dropped, not queued.
        mem[1] = 32'hDEADBEEF;
        iReq = 1'b1; iWrite = 1'b0; iFunct3 = 3'b010; iAddr = 32'h10010004;
        tick();
        iWrite = 1'b1; iAddr = 32'h10010008; iWData = 32'h55555555;
        we_seen = 0; wait_n = 0;
        while (!oDone && wait_n < 20) begin
            we_seen += int'(oWriteEnable);
            tick();
            wait_n++;
        end
        iReq = 1'b0;
        chk("busy done_cycle", 32'(wait_n + 1), 32'd3);
        chk("busy rdata", oRData, 32'hDEADBEEF);
        for (int k = 0; k < 3; k++) begin
            tick();
            we_seen += int'(oWriteEnable) + int'(oReadEnable);
        end
        chk("busy dropped", 32'(we_seen), 32'h0);
        chk("busy ready", 32'(oReady), 32'h1);

        // Reset in the middle of a store phase aborts the access.
        iReq = 1'b1; iWrite = 1'b1; iFunct3 = 3'b010; iAddr = 32'h10010000; iWData = 32'h11111111;
        tick();
        iReq = 1'b0;
        chk("abort we_issued", 32'(oWriteEnable), 32'h1);
        iRST_n = 1'b0;
        tick();
        chk("abort ready", 32'(oReady), 32'h1);
        chk("abort enables", {30'b0, oReadEnable, oWriteEnable}, 32'h0);
        chk("abort be", 32'(oByteEnable), 32'h0);
        chk("abort addr", oAddress, 32'h0);
        chk("abort wdata", oWriteData, 32'h0);
        chk("abort done", 32'(oDone), 32'h0);
        chk("abort rdata", oRData, 32'h0);
        iRST_n = 1'b1;
        tick();
        chk("abort idle done", 32'(oDone), 32'h0);
        chk("abort idle ready", 32'(oReady), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
